// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: controller state encoding,
// header address constants and port indices.
package router_pkg;

  // Number of output ports served by the router
  localparam int NUM_PORTS = 3;

  // Controller state encoding (3-bit binary)
  typedef logic [2:0] state_t;

  localparam state_t DECODE_ADDRESS     = 3'd0;
  localparam state_t WAIT_TILL_EMPTY    = 3'd1;
  localparam state_t LOAD_FIRST_DATA    = 3'd2;
  localparam state_t LOAD_DATA          = 3'd3;
  localparam state_t FIFO_FULL_STATE    = 3'd4;
  localparam state_t LOAD_AFTER_FULL    = 3'd5;
  localparam state_t LOAD_PARITY        = 3'd6;
  localparam state_t CHECK_PARITY_ERROR = 3'd7;

  // Header address value that selects no port
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Port indices shared by the synchronizer and the controller
  localparam int PORT0 = 0;
  localparam int PORT1 = 1;
  localparam int PORT2 = 2;

  // True when a header address selects a real port
  function automatic logic addr_is_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-level controller for the router input path. Decodes the header
// address, waits for the selected FIFO to drain, sequences the header /
// payload / parity loads and stalls the source while the FIFO is full.
module router_fsm
  import router_pkg::*;
#(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  input  logic [ADDR_WIDTH-1:0] d_in,
  input  logic                  fifo_full,
  input  logic                  empty_0,
  input  logic                  empty_1,
  input  logic                  empty_2,
  input  logic                  soft_rst_0,
  input  logic                  soft_rst_1,
  input  logic                  soft_rst_2,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  write_enb_reg,
  output logic                  rst_int_reg,
  output logic                  busy
);

  // Every encodable address gets a slot so indexing by address is always in range
  localparam int NUM_SEL = 1 << ADDR_WIDTH;

  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;

  logic [NUM_PORTS-1:0]  port_empty;
  logic [NUM_PORTS-1:0]  port_soft_rst;
  logic [NUM_SEL-1:0]    sel_empty;
  logic [NUM_SEL-1:0]    sel_soft_rst;
  logic                  addr_ok;
  logic                  soft_hit;

  assign port_empty[PORT0]    = empty_0;
  assign port_empty[PORT1]    = empty_1;
  assign port_empty[PORT2]    = empty_2;
  assign port_soft_rst[PORT0] = soft_rst_0;
  assign port_soft_rst[PORT1] = soft_rst_1;
  assign port_soft_rst[PORT2] = soft_rst_2;

  // Address-indexed views of the per-port status; the invalid slot reads 0
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEL; gi++) begin : g_sel
      if (gi < NUM_PORTS) begin : g_port
        assign sel_empty[gi]    = port_empty[gi];
        assign sel_soft_rst[gi] = port_soft_rst[gi];
      end else begin : g_pad
        assign sel_empty[gi]    = 1'b0;
        assign sel_soft_rst[gi] = 1'b0;
      end
    end
  endgenerate

  assign addr_ok  = addr_is_valid(2'(d_in));
  // Only the soft reset of the port currently owned by the packet matters
  assign soft_hit = (state_reg != DECODE_ADDRESS) && sel_soft_rst[addr_reg];

  // State and captured address registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DECODE_ADDRESS;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  // Next-state and address-capture logic; soft reset overrides everything
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    if (soft_hit) begin
      state_next = DECODE_ADDRESS;
    end else begin
      case (state_reg)
        DECODE_ADDRESS: begin
          if (pkt_valid && addr_ok) begin
            addr_next  = d_in;
            state_next = sel_empty[d_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (sel_empty[addr_reg]) state_next = LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_next = FIFO_FULL_STATE;
          else if (!pkt_valid) state_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_next = DECODE_ADDRESS;
          else if (low_pkt_valid) state_next = LOAD_PARITY;
          else                    state_next = LOAD_DATA;
        end
        LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: state_next = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode straight from the registered state
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    case (state_reg)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY:        write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
      default: ;
    endcase
  end

endmodule
